// File: rtl/phase_pkg.sv
// phase_pkg: shared FSM encoding and timing constants for the phase readout path
package phase_pkg;
  localparam int CORDIC_LATENCY = 28;
  localparam int BRAM_READ_LATENCY = 2;
  localparam int SETTLE_DEFAULT = CORDIC_LATENCY + BRAM_READ_LATENCY;
  localparam int PHASE_W = 24;
  typedef enum logic [2:0] {IDLE, SETTLE, WAIT_PEAK, ISSUE, WAIT_RESULT, OUTPUT} state_t;
endpackage

// File: rtl/phase_wrap_sub.sv
// phase_wrap_sub: registered modulo-2**W phase difference a - b
module phase_wrap_sub #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);
  always_ff @(posedge clock)
    if (reset) d <= '0;
    else if (en) d <= a - b;
endmodule

// File: rtl/phase_readout_sequencer.sv
// phase_readout_sequencer: per-window k_max query and wrapped phase-advance readout
module phase_readout_sequencer import phase_pkg::*; #(
  parameter int ADDR_WIDTH = 11,
  parameter int PHASE_WIDTH = PHASE_W,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fft_tvalid,
  input  logic                   fft_tlast,
  input  logic                   cordic_tready,
  input  logic [ADDR_WIDTH-1:0]  peak_k,
  input  logic                   peak_valid,
  output logic                   peak_ready,
  output logic [ADDR_WIDTH-1:0]  pd_k_max,
  output logic                   pd_k_max_valid,
  input  logic [PHASE_WIDTH-1:0] pd_phase,
  input  logic [PHASE_WIDTH-1:0] pd_phase_last,
  input  logic                   pd_phases_valid,
  output logic [ADDR_WIDTH-1:0]  out_k,
  output logic [PHASE_WIDTH-1:0] out_dphase,
  output logic                   out_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_timeout,
  output logic                   err_drop
);
  localparam int TW = $clog2((SETTLE_CYCLES > TIMEOUT ? SETTLE_CYCLES : TIMEOUT) + 1);
  localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic first_pending, pending_frame, pend_n, take_k, take_res, beat, tl;
  assign beat = fft_tvalid & cordic_tready;
  assign tl = beat & fft_tlast;
  assign out_valid = state == OUTPUT;
  always_comb begin
    state_n = state;
    timer_n = timer;
    pend_n = pending_frame;
    peak_ready = 1'b0;
    err_drop = 1'b0;
    err_timeout = 1'b0;
    take_k = 1'b0;
    take_res = 1'b0;
    case (state)
      IDLE: begin
        state_n = tl ? SETTLE : IDLE;
        timer_n = tl ? SET_LOAD : timer;
      end
      SETTLE:
        // a new frame overwrites the phase RAM; its own tlast restarts the settle
        if (beat) begin
          err_drop = 1'b1;
          state_n = tl ? SETTLE : IDLE;
          timer_n = SET_LOAD;
        end else if (timer == '0) state_n = WAIT_PEAK;
        else timer_n = timer - 1'b1;
      WAIT_PEAK: begin
        peak_ready = 1'b1;
        take_k = peak_valid & ~peak_k[ADDR_WIDTH-1];
        err_drop = peak_valid & peak_k[ADDR_WIDTH-1];
        state_n = !peak_valid ? WAIT_PEAK : take_k ? ISSUE : IDLE;
      end
      ISSUE: begin
        state_n = WAIT_RESULT;
        timer_n = TO_LOAD;
      end
      WAIT_RESULT:
        if (pd_phases_valid) begin
          take_res = 1'b1;
          state_n = OUTPUT;
          pend_n = tl;
        end else if (beat) begin
          err_drop = 1'b1;
          state_n = IDLE;
        end else if (timer == '0) begin
          err_timeout = 1'b1;
          state_n = IDLE;
        end else timer_n = timer - 1'b1;
      OUTPUT: begin
        pend_n = pending_frame | tl;
        if (out_ready) begin
          state_n = (pending_frame | tl) ? SETTLE : IDLE;
          timer_n = SET_LOAD;
          pend_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      first_pending <= 1'b1;
      pending_frame <= 1'b0;
      pd_k_max <= '0;
      pd_k_max_valid <= 1'b0;
      out_k <= '0;
      out_first <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pending_frame <= pend_n;
      pd_k_max_valid <= take_k;
      if (take_k) pd_k_max <= peak_k;
      if (take_res) begin
        out_k <= pd_k_max;
        out_first <= first_pending;
        first_pending <= 1'b0;
      end
    end
  phase_wrap_sub #(.W(PHASE_WIDTH)) u_wrap (
    .clock(clock),
    .reset(reset),
    .en(take_res),
    .a(pd_phase),
    .b(pd_phase_last),
    .d(out_dphase)
  );
endmodule

// File: tb/tb_phase_readout_sequencer.sv
// tb_phase_readout_sequencer: randomized scenario bench with timing/value model from the block's rules
module tb_phase_readout_sequencer;
  localparam int AW = 11;
  localparam int PW = 24;
  localparam int SET = 30;
  localparam int TO = 64;
  logic clock = 1'b0, reset = 1'b1;
  logic fft_tvalid = 1'b0, fft_tlast = 1'b0, cordic_tready = 1'b0;
  logic [AW-1:0] peak_k = '0;
  logic peak_valid = 1'b0, peak_ready;
  logic [AW-1:0] pd_k_max;
  logic pd_k_max_valid;
  logic [PW-1:0] pd_phase = '0, pd_phase_last = '0;
  logic pd_phases_valid = 1'b0;
  logic [AW-1:0] out_k;
  logic [PW-1:0] out_dphase;
  logic out_first, out_valid, out_ready = 1'b0, err_timeout, err_drop;
  int cyc = 0, checks = 0, failures = 0;
  int n_strobe = 0, n_to = 0, n_drop = 0, n_ov = 0;
  logic model_first = 1'b1;

  phase_readout_sequencer dut (
    .clock(clock), .reset(reset), .fft_tvalid(fft_tvalid), .fft_tlast(fft_tlast),
    .cordic_tready(cordic_tready), .peak_k(peak_k), .peak_valid(peak_valid),
    .peak_ready(peak_ready), .pd_k_max(pd_k_max), .pd_k_max_valid(pd_k_max_valid),
    .pd_phase(pd_phase), .pd_phase_last(pd_phase_last), .pd_phases_valid(pd_phases_valid),
    .out_k(out_k), .out_dphase(out_dphase), .out_first(out_first), .out_valid(out_valid),
    .out_ready(out_ready), .err_timeout(err_timeout), .err_drop(err_drop)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (!reset) begin
      if (pd_k_max_valid) n_strobe++;
      if (err_timeout) n_to++;
      if (err_drop) n_drop++;
      if (out_valid) n_ov++;
    end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input int n, output int tl_cyc);
    int b = 0;
    tl_cyc = 0;
    while (b < n) begin
      @(posedge clock); #1;
      fft_tvalid = $urandom_range(0, 3) != 0;
      cordic_tready = $urandom_range(0, 4) != 0;
      fft_tlast = (b == n - 1);
      if (fft_tvalid && cordic_tready) begin
        b++;
        tl_cyc = cyc;
      end
    end
    @(posedge clock); #1;
    fft_tvalid = 1'b0;
    fft_tlast = 1'b0;
    cordic_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic present_peak(input logic [AW-1:0] k, input int exp_c, output int s);
    int n = 0;
    peak_k = k;
    peak_valid = 1'b1;
    @(negedge clock);
    while (!peak_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (peak_ready !== 1'b1 || cyc != exp_c) begin
      failures++;
      $display("FAIL peak_ready_timing: ready=%0b at cycle %0d, required 1 at cycle %0d", peak_ready, cyc, exp_c);
    end
    @(posedge clock); #1;
    peak_valid = 1'b0;
    peak_k = AW'($urandom);
    @(negedge clock);
    s = cyc;
    checks++;
    if (pd_k_max_valid !== 1'b1 || pd_k_max !== k || peak_ready !== 1'b0) begin
      failures++;
      $display("FAIL strobe: valid=%0b k=%0d ready=%0b, required valid=1 k=%0d ready=0", pd_k_max_valid, pd_k_max, peak_ready, k);
    end
  endtask

  task automatic give_result(input logic [PW-1:0] ph, input logic [PW-1:0] pl, input int delay);
    repeat (delay) @(posedge clock);
    #1;
    pd_phase = ph;
    pd_phase_last = pl;
    pd_phases_valid = 1'b1;
    @(posedge clock); #1;
    pd_phases_valid = 1'b0;
    pd_phase = PW'($urandom);
    pd_phase_last = PW'($urandom);
  endtask

  task automatic check_output(input logic [AW-1:0] k, input logic [PW-1:0] ph, input logic [PW-1:0] pl,
                              input int hold, input bit inj, output int h);
    logic [PW-1:0] e;
    e = ph - pl;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_k !== k || out_dphase !== e || out_first !== model_first) begin
      failures++;
      $display("FAIL result: valid=%0b k=%0d dphase=%h first=%0b, required 1 %0d %h %0b", out_valid, out_k, out_dphase, out_first, k, e, model_first);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      fft_tvalid = inj && i == 3;
      fft_tlast = fft_tvalid;
      cordic_tready = 1'b1;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_k !== k || out_dphase !== e || out_first !== model_first) begin
        failures++;
        $display("FAIL hold_stable[%0d]: valid=%0b k=%0d dphase=%h first=%0b, required 1 %0d %h %0b", i, out_valid, out_k, out_dphase, out_first, k, e, model_first);
      end
    end
    @(posedge clock); #1;
    fft_tvalid = 1'b0;
    fft_tlast = 1'b0;
    out_ready = 1'b1;
    h = cyc;
    @(posedge clock); #1;
    out_ready = 1'b0;
    model_first = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_after_handshake: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic do_window(input int len, input logic [AW-1:0] k, input logic [PW-1:0] ph,
                           input logic [PW-1:0] pl, input int delay, input int hold);
    int tl, s, h, s0;
    s0 = n_strobe;
    send_frame(len, tl);
    present_peak(k, tl + SET + 1, s);
    give_result(ph, pl, delay);
    check_output(k, ph, pl, hold, 1'b0, h);
    checks++;
    if (n_strobe - s0 != 1) begin
      failures++;
      $display("FAIL strobe_count: %0d strobes, required 1", n_strobe - s0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_first = 1'b1;
    @(negedge clock);
    checks++;
    if ({peak_ready, pd_k_max_valid, out_valid, out_first, err_timeout, err_drop} !== 6'b0 ||
        pd_k_max !== '0 || out_k !== '0 || out_dphase !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ctl=%b k=%0d ok=%0d dp=%h, required all 0",
               {peak_ready, pd_k_max_valid, out_valid, out_first, err_timeout, err_drop}, pd_k_max, out_k, out_dphase);
    end
  endtask

  task automatic test_basic;
    do_window(1024, 11'd37, 24'h000100, 24'h7FFF00, 3, 2);
    do_window(1024, AW'($urandom_range(0, 1023)), PW'($urandom), PW'($urandom), 3, 1);
  endtask

  task automatic test_wrap;
    do_window(20, 11'd5, 24'h000010, 24'hFFFFF0, 2, 0);
  endtask

  task automatic test_random;
    repeat (6)
      do_window($urandom_range(4, 60), AW'($urandom_range(0, 1023)), PW'($urandom), PW'($urandom),
                $urandom_range(1, TO), $urandom_range(0, 4));
  endtask

  task automatic test_settle_beat;
    int tl, b, s, h, d0;
    d0 = n_drop;
    send_frame(12, tl);
    repeat (5) @(posedge clock);
    #1;
    fft_tvalid = 1'b1;
    cordic_tready = 1'b1;
    fft_tlast = 1'b1;
    b = cyc;
    @(negedge clock);
    checks++;
    if (err_drop !== 1'b1) begin
      failures++;
      $display("FAIL settle_beat_drop: err_drop=%0b, required 1", err_drop);
    end
    @(posedge clock); #1;
    fft_tvalid = 1'b0;
    fft_tlast = 1'b0;
    present_peak(11'd200, b + SET + 1, s);
    give_result(24'h123456, 24'h000456, 4);
    check_output(11'd200, 24'h123456, 24'h000456, 0, 1'b0, h);
    checks++;
    if (n_drop - d0 != 1) begin
      failures++;
      $display("FAIL settle_drop_count: %0d, required 1", n_drop - d0);
    end
  endtask

  task automatic test_timeout;
    int tl, s, n, o0;
    o0 = n_ov;
    send_frame(16, tl);
    present_peak(11'd99, tl + SET + 1, s);
    n = 0;
    @(negedge clock);
    while (!err_timeout && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (err_timeout !== 1'b1 || cyc != s + TO) begin
      failures++;
      $display("FAIL timeout_timing: err_timeout=%0b at cycle %0d, required 1 at cycle %0d", err_timeout, cyc, s + TO);
    end
    @(posedge clock); #1;
    pd_phases_valid = 1'b1;
    @(negedge clock);
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: err_timeout=%0b, required 0", err_timeout);
    end
    @(posedge clock); #1;
    pd_phases_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || n_ov != o0) begin
      failures++;
      $display("FAIL timeout_no_output: out_valid=%0b cycles=%0d, required 0 0", out_valid, n_ov - o0);
    end
    do_window(10, 11'd1023, 24'h000001, 24'h000002, 5, 1);
  endtask

  task automatic test_drop_wait;
    int tl, s, d0, o0;
    d0 = n_drop;
    o0 = n_ov;
    send_frame(16, tl);
    present_peak(11'd64, tl + SET + 1, s);
    @(posedge clock); #1;
    fft_tvalid = 1'b1;
    cordic_tready = 1'b1;
    fft_tlast = 1'b0;
    @(negedge clock);
    checks++;
    if (err_drop !== 1'b1) begin
      failures++;
      $display("FAIL wait_beat_drop: err_drop=%0b, required 1", err_drop);
    end
    @(posedge clock); #1;
    fft_tvalid = 1'b0;
    give_result(24'h00ABCD, 24'h000001, 2);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || n_ov != o0 || n_drop - d0 != 1) begin
      failures++;
      $display("FAIL wait_drop_no_output: out_valid=%0b cycles=%0d drops=%0d, required 0 0 1", out_valid, n_ov - o0, n_drop - d0);
    end
    do_window(24, 11'd300, PW'($urandom), PW'($urandom), 7, 0);
  endtask

  task automatic test_drop_range;
    int tl, n, s0;
    logic [AW-1:0] k;
    s0 = n_strobe;
    k = AW'(1024 + $urandom_range(0, 1023));
    send_frame(16, tl);
    peak_k = 11'd1024;
    peak_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!peak_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (peak_ready !== 1'b1 || cyc != tl + SET + 1 || err_drop !== 1'b1) begin
      failures++;
      $display("FAIL range_drop: ready=%0b drop=%0b cycle=%0d, required 1 1 %0d", peak_ready, err_drop, cyc, tl + SET + 1);
    end
    peak_k = k;
    #1;
    checks++;
    if (err_drop !== 1'b1) begin
      failures++;
      $display("FAIL range_drop_random: k=%0d err_drop=%0b, required 1", k, err_drop);
    end
    @(posedge clock); #1;
    peak_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (pd_k_max_valid !== 1'b0 || peak_ready !== 1'b0 || err_drop !== 1'b0 || n_strobe != s0) begin
      failures++;
      $display("FAIL range_no_query: strobe=%0b ready=%0b drop=%0b strobes=%0d, required 0 0 0 0", pd_k_max_valid, peak_ready, err_drop, n_strobe - s0);
    end
    do_window(16, 11'd512, PW'($urandom), PW'($urandom), 1, 0);
  endtask

  task automatic test_back_to_back;
    int tl, s, h, s2, h2;
    logic [PW-1:0] ph, pl;
    ph = PW'($urandom);
    pl = PW'($urandom);
    send_frame(32, tl);
    present_peak(11'd77, tl + SET + 1, s);
    give_result(ph, pl, 3);
    check_output(11'd77, ph, pl, 10, 1'b1, h);
    present_peak(11'd78, h + SET + 1, s2);
    give_result(pl, ph, 2);
    check_output(11'd78, pl, ph, 0, 1'b0, h2);
  endtask

  task automatic test_reset_mid;
    int tl, s, o0;
    send_frame(16, tl);
    present_peak(11'd400, tl + SET + 1, s);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_first = 1'b1;
    @(negedge clock);
    checks++;
    if ({peak_ready, pd_k_max_valid, out_valid, out_first, err_timeout, err_drop} !== 6'b0 ||
        pd_k_max !== '0 || out_k !== '0 || out_dphase !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: ctl=%b k=%0d ok=%0d dp=%h, required all 0",
               {peak_ready, pd_k_max_valid, out_valid, out_first, err_timeout, err_drop}, pd_k_max, out_k, out_dphase);
    end
    o0 = n_ov;
    give_result(24'h111111, 24'h000001, 1);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || n_ov != o0) begin
      failures++;
      $display("FAIL reset_mid_ignored: out_valid=%0b, required 0", out_valid);
    end
    do_window(16, 11'd9, 24'h000100, 24'h7FFF00, 3, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_settle_beat();
    test_timeout();
    test_drop_wait();
    test_drop_range();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (n_to != 1) begin
      failures++;
      $display("FAIL timeout_total: %0d timeouts, required 1", n_to);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phase_readout_sequencer.md
Name: phase_readout_sequencer

Overview:
- Per-window controller in front of phase_detector.
- Tracks DFT frame boundaries and holds off the k_max query until the phase RAM is fully written.
- Issues exactly one k_max query per window, then waits for phases_valid with a timeout.
- Returns the wrapped phase advance (phase - phase_last) to the pitch-estimation stage over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 11, log2 DFT size; query index range is 0..2**(ADDR_WIDTH-1)-1.
- PHASE_WIDTH, 24, phase word width.
- SETTLE_CYCLES, 30, cycles after the tlast beat before querying (CORDIC_LATENCY 28 + 2).
- TIMEOUT, 64, maximum cycles from query to phases_valid.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fft_tvalid  in  1  DFT stream valid (monitored only)
- fft_tlast  in  1  DFT stream last (monitored only)
- cordic_tready  in  1  phase_detector ready; a beat is accepted when fft_tvalid & cordic_tready
- peak_k  in  ADDR_WIDTH  peak bin from the peak finder
- peak_valid  in  1  peak_k valid
- peak_ready  out  1  peak accepted
- pd_k_max  out  ADDR_WIDTH  query index to phase_detector
- pd_k_max_valid  out  1  single-cycle query strobe
- pd_phase  in  PHASE_WIDTH  current-window phase
- pd_phase_last  in  PHASE_WIDTH  previous-window phase
- pd_phases_valid  in  1  phase outputs valid
- out_k  out  ADDR_WIDTH  bin index of the result
- out_dphase  out  PHASE_WIDTH  phase minus phase_last, wrapped
- out_first  out  1  no valid previous window exists
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- err_timeout  out  1  one-cycle pulse
- err_drop  out  1  one-cycle pulse

Behaviour:
- Reset state: IDLE. All outputs 0; first_pending = 1; timer = 0.
- Clock and reset are a single clock `clock` and a synchronous, active-high `reset`. Reset mid-operation abandons any query and discards any held result.
- IDLE: on an accepted beat with fft_tlast = 1, go to SETTLE and load timer = SETTLE_CYCLES-1.
- SETTLE: decrement the timer each cycle; when it reaches 0, go to WAIT_PEAK. An accepted beat here (next frame already starting) means the phase RAM is being overwritten: pulse err_drop, return to IDLE, and re-evaluate tlast on that same beat.
- WAIT_PEAK: peak_ready = 1 combinationally in this state only.
  - On peak_valid & peak_ready with peak_k < 2**(ADDR_WIDTH-1): latch k, go to ISSUE.
  - If peak_k is out of range: accept the peak, pulse err_drop, go to IDLE.
- ISSUE: drive pd_k_max = k and pd_k_max_valid = 1 for exactly one cycle (registered outputs). pd_k_max holds k until the next ISSUE. Then go to WAIT_RESULT with timer = TIMEOUT-1.
- WAIT_RESULT:
  - On pd_phases_valid: register out_k = k, out_dphase = pd_phase - pd_phase_last (modulo 2**PHASE_WIDTH, natural two's-complement wrap), and out_first = first_pending. Clear first_pending; go to OUTPUT.
  - Timer expiry without pd_phases_valid: pulse err_timeout, go to IDLE.
  - An accepted fft beat before the result: pulse err_drop, go to IDLE.
  - An accepted beat and pd_phases_valid in the same cycle: the result wins.
- OUTPUT: out_valid = 1; out_k, out_dphase and out_first are stable while out_valid & !out_ready. On out_valid & out_ready go to IDLE, and out_valid is low the next cycle.
  - If an accepted tlast beat arrives while in OUTPUT, latch a pending_frame flag so the transfer goes directly to SETTLE instead of IDLE.
- pd_phases_valid outside WAIT_RESULT is ignored.
- Latency:
  - tlast beat to peak_ready is SETTLE_CYCLES+1 cycles.
  - Accepted peak to pd_k_max_valid is 1 cycle.
  - pd_phases_valid to out_valid is 1 cycle.
- Max throughput is one result per frame.

Decomposition:
- Shared package phase_pkg:
  - FSM state encoding (IDLE, SETTLE, WAIT_PEAK, ISSUE, WAIT_RESULT, OUTPUT)
  - CORDIC_LATENCY = 28 and BRAM_READ_LATENCY = 2, with SETTLE_CYCLES derived from them
  - phase word width
- One natural sub-module: phase_wrap_sub, a registered wrapped subtract producing out_dphase; everything else stays inline.

Test Plan:
- Frame of 1024 beats (tlast on the last), peak_k = 37 after settle, pd_phases_valid 3 cycles after the strobe with phase = 0x000100 and last = 0x7FFF00 -> one pd_k_max_valid with k = 37; out_dphase = 0x800200; out_first = 1; second frame gives out_first = 0.
- Wrap case: phase = 0x000010, last = 0xFFFFF0 -> out_dphase = 0x000020.
- Peak presented during SETTLE -> peak_ready stays 0 until exactly SETTLE_CYCLES+1 cycles after the tlast beat.
- No pd_phases_valid after the query -> err_timeout pulses at TIMEOUT = 64 cycles after the strobe; state returns to IDLE; out_valid is never asserted.
- New frame beat during WAIT_RESULT, and separately peak_k = 1024 -> err_drop pulses, no output; next frame processed normally.
- out_ready held low 10 cycles with tlast of the next frame arriving meanwhile -> outputs stable for 10 cycles; after the handshake the FSM enters SETTLE directly; reset asserted mid-WAIT_RESULT -> all outputs 0 the next cycle.
